// File: rtl/mips_defs.sv
// Shared MIPS core definitions: control codes for jumps/branches, reset vector and NOP.
package mips_defs;

    localparam logic [1:0] JUMP_NONE   = 2'b00;
    localparam logic [1:0] JUMP_J      = 2'b01;
    localparam logic [1:0] JUMP_JR     = 2'b10;
    localparam logic [1:0] JUMP_JAL    = 2'b11;

    localparam logic [1:0] BRANCH_NONE = 2'b00;
    localparam logic [1:0] BRANCH_BEQ  = 2'b10;
    localparam logic [1:0] BRANCH_BNE  = 2'b11;

    localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    // Source selected for the next fetch address.
    typedef enum logic [2:0] {
        REDIR_SEQ,
        REDIR_HOLD,
        REDIR_JUMP,
        REDIR_JR,
        REDIR_BRANCH
    } redir_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage, including the misaligned-target flag.
module next_pc_calc
    import mips_defs::*;
(
    input  logic        i_stall,
    input  logic        i_id_valid,
    input  logic [31:0] i_id_pc,
    input  logic [25:0] i_id_inst_lo,
    input  logic [1:0]  i_id_jump,
    input  logic [1:0]  i_id_branch,
    input  logic        i_id_zero,
    input  logic [31:0] i_id_rs_data,
    input  logic [31:0] i_pc_q,
    output logic [31:0] o_next_pc,
    output logic        o_fetch_adel
);

    logic [31:0] w_seq_pc;
    logic [15:0] w_imm16;
    logic [31:0] w_j_target;
    logic [31:0] w_br_target;
    logic [31:0] w_target;
    logic        w_br_taken;
    logic        w_redirect;
    redir_e      w_kind;

    assign w_seq_pc    = i_id_pc + 32'd4;
    assign w_imm16     = i_id_inst_lo[15:0];
    assign w_j_target  = {w_seq_pc[31:28], i_id_inst_lo, 2'b00};
    assign w_br_target = w_seq_pc + {{14{w_imm16[15]}}, w_imm16, 2'b00};

    // Codes outside the listed set fall to default, so an undefined decode never redirects.
    always_comb begin
        w_br_taken = 1'b0;
        case (i_id_branch)
            BRANCH_BEQ: w_br_taken = i_id_zero;
            BRANCH_BNE: w_br_taken = !i_id_zero;
            default:    w_br_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_kind = REDIR_SEQ;
        if (i_stall) begin
            w_kind = REDIR_HOLD;
        end else if (i_id_valid) begin
            case (i_id_jump)
                JUMP_J, JUMP_JAL: w_kind = REDIR_JUMP;
                JUMP_JR:          w_kind = REDIR_JR;
                default:          if (w_br_taken) w_kind = REDIR_BRANCH;
            endcase
        end
    end

    always_comb begin
        w_target = i_pc_q + 32'd4;
        case (w_kind)
            REDIR_HOLD:   w_target = i_pc_q;
            REDIR_JUMP:   w_target = w_j_target;
            REDIR_JR:     w_target = i_id_rs_data;
            REDIR_BRANCH: w_target = w_br_target;
            default:      w_target = i_pc_q + 32'd4;
        endcase
    end

    assign w_redirect   = (w_kind == REDIR_JUMP) || (w_kind == REDIR_JR) || (w_kind == REDIR_BRANCH);
    assign o_fetch_adel = w_redirect && (w_target[1:0] != 2'b00);
    assign o_next_pc    = w_redirect ? {w_target[31:2], 2'b00} : w_target;

endmodule

// File: rtl/inst_fetch.sv
// MIPS IF stage and IF/ID register: owns the PC, drives the synchronous inst SRAM,
// and presents the fetched instruction to decode with an architectural branch delay slot.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = mips_defs::RESET_PC
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  id_jump,
    input  logic [1:0]  id_branch,
    input  logic        id_zero,
    input  logic [31:0] id_rs_data,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [31:0] id_link_pc,
    output logic        fetch_adel
);

    logic [31:0] r_pc_q;
    logic        r_rd_valid_q;
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic [31:0] w_next_pc;
    logic        w_fetch_adel;

    next_pc_calc u_next_pc_calc (
        .i_stall      (stall),
        .i_id_valid   (r_id_valid),
        .i_id_pc      (r_id_pc),
        .i_id_inst_lo (r_id_inst[25:0]),
        .i_id_jump    (id_jump),
        .i_id_branch  (id_branch),
        .i_id_zero    (id_zero),
        .i_id_rs_data (id_rs_data),
        .i_pc_q       (r_pc_q),
        .o_next_pc    (w_next_pc),
        .o_fetch_adel (w_fetch_adel)
    );

    // r_pc_q is the address whose data is on inst_sram_rdata this cycle; a stall re-issues it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_q       <= RESET_PC - 32'd4;
            r_rd_valid_q <= 1'b0;
        end else begin
            r_pc_q       <= w_next_pc;
            r_rd_valid_q <= 1'b1;
        end
    end

    // Flow control: stall is the only handshake; while high, PC and IF/ID hold and nothing is
    // consumed; an instruction moves IF->ID on every edge where stall is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= 32'h0;
            r_id_inst  <= mips_defs::NOP;
        end else if (!stall) begin
            r_id_valid <= r_rd_valid_q;
            r_id_pc    <= r_pc_q;
            r_id_inst  <= r_rd_valid_q ? inst_sram_rdata : mips_defs::NOP;
        end
    end

    assign inst_sram_en    = !reset;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = w_next_pc;
    assign inst_sram_wdata = 32'h0;

    assign id_valid   = r_id_valid;
    assign id_pc      = r_id_pc;
    assign id_inst    = r_id_inst;
    assign id_link_pc = r_id_pc + 32'd8;
    assign fetch_adel = w_fetch_adel && !reset;

endmodule
